// File: rtl/dec_scan.sv
// rtl/dec_scan.sv - registered N-to-one-hot select with direct-load and auto-scan modes
module dec_scan #(
  parameter int SEL_W      = 4,
  parameter int NUM_OUT    = 16,
  parameter int PRESCALE   = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               mode,
  input  logic               load,
  input  logic [SEL_W-1:0]   s,
  output logic [NUM_OUT-1:0] out,
  output logic [SEL_W-1:0]   idx,
  output logic               wrap,
  output logic               oor
);

  localparam int                 CNT_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [SEL_W-1:0]   IDX_LAST  = SEL_W'(NUM_OUT - 1);
  localparam logic [SEL_W:0]     NUM_OUT_X = (SEL_W + 1)'(NUM_OUT);
  localparam logic [NUM_OUT-1:0] OUT_OFF   = {NUM_OUT{ACTIVE_LOW}};

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 wrap_q, wrap_d;
  logic                 oor_q, oor_d;
  logic [NUM_OUT-1:0]   out_q, out_d;
  logic [NUM_OUT-1:0]   onehot;
  logic                 s_legal;

  assign s_legal = ({1'b0, s} < NUM_OUT_X);

  // Mode is taken from the inputs sampled at this edge, so outputs follow en/mode with one clock latency.
  always_comb begin
    state_d = !en ? IDLE : (mode ? SCAN : DIRECT);
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    oor_d   = 1'b0;
    case (state_d)
      DIRECT: begin
        cnt_d = '0;
        if (load) begin
          if (s_legal) idx_d = s;
          else         oor_d = 1'b1;
        end
      end
      SCAN: begin
        if (load && s_legal) begin
          idx_d = s;
          cnt_d = '0;
        end else begin
          oor_d = load;
          if (state_q != SCAN) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end else begin
              idx_d = idx_q + SEL_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: cnt_d = '0;
    endcase

    onehot = '0;
    for (int i = 0; i < NUM_OUT; i++) onehot[i] = (idx_d == SEL_W'(i));
    if (state_d == IDLE) out_d = OUT_OFF;
    else                 out_d = ACTIVE_LOW ? ~onehot : onehot;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      oor_q   <= 1'b0;
      out_q   <= OUT_OFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      wrap_q  <= wrap_d;
      oor_q   <= oor_d;
      out_q   <= out_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign oor  = oor_q;

endmodule

// File: tb/tb_dec_scan.sv
// tb/tb_dec_scan.sv - scoreboard bench driving three dec_scan variants from shared random stimulus
module tb_dec_scan;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       en    = 1'b1;
  logic       mode  = 1'b1;
  logic       load  = 1'b0;
  logic [3:0] s     = 4'd0;

  logic [15:0] out_a, out_c;
  logic [9:0]  out_b;
  logic [3:0]  idx_a, idx_b, idx_c;
  logic        wrap_a, wrap_b, wrap_c;
  logic        oor_a, oor_b, oor_c;

  always #5 clk = ~clk;

  dec_scan #(.SEL_W(4), .NUM_OUT(16), .PRESCALE(4), .ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .s(s),
    .out(out_a), .idx(idx_a), .wrap(wrap_a), .oor(oor_a));
  dec_scan #(.SEL_W(4), .NUM_OUT(10), .PRESCALE(4), .ACTIVE_LOW(1'b0)) u_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .s(s),
    .out(out_b), .idx(idx_b), .wrap(wrap_b), .oor(oor_b));
  dec_scan #(.SEL_W(4), .NUM_OUT(16), .PRESCALE(1), .ACTIVE_LOW(1'b1)) u_c (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load), .s(s),
    .out(out_c), .idx(idx_c), .wrap(wrap_c), .oor(oor_c));

  typedef struct packed {
    logic [15:0] out;
    logic [3:0]  idx;
    logic        wrap;
    logic        oor;
  } res_t;
  typedef res_t [2:0] trio_t;

  trio_t sb[$];

  int nn[3] = '{16, 10, 16};
  int pp[3] = '{4, 4, 1};
  bit al[3] = '{1'b0, 1'b0, 1'b1};

  // Behavioural model: index, cycles dwelt on it, and whether the previous cycle was scanning.
  int m_idx[3];
  int m_dwell[3];
  bit m_scan[3];
  bit m_on[3];
  bit m_wrap[3];
  bit m_oor[3];

  int checks = 0;
  int errors = 0;

  function automatic res_t expect_of(int i);
    res_t r;
    logic [15:0] mask;
    logic [15:0] o;
    mask = 16'((1 << nn[i]) - 1);
    o = m_on[i] ? 16'(1 << m_idx[i]) : 16'h0000;
    if (al[i]) o = ~o & mask;
    r.out  = o;
    r.idx  = 4'(m_idx[i]);
    r.wrap = m_wrap[i];
    r.oor  = m_oor[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_idx[i] = 0; m_dwell[i] = 0; m_scan[i] = 0;
      m_on[i] = 0; m_wrap[i] = 0; m_oor[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      m_wrap[i] = 0;
      m_oor[i]  = 0;
      m_on[i]   = en;
      if (!en) begin
        m_scan[i] = 0;
      end else if (!mode) begin
        m_scan[i] = 0;
        if (load) begin
          if (int'(s) < nn[i]) m_idx[i] = int'(s);
          else                 m_oor[i] = 1;
        end
      end else begin
        if (load && int'(s) < nn[i]) begin
          m_idx[i]   = int'(s);
          m_dwell[i] = 0;
        end else begin
          m_oor[i] = load;
          if (!m_scan[i]) begin
            m_dwell[i] = 0;
          end else begin
            m_dwell[i]++;
            if (m_dwell[i] == pp[i]) begin
              m_dwell[i] = 0;
              m_idx[i]   = (m_idx[i] + 1) % nn[i];
              m_wrap[i]  = (m_idx[i] == 0);
            end
          end
        end
        m_scan[i] = 1;
      end
    end
  endtask

  task automatic push_exp();
    trio_t t;
    for (int i = 0; i < 3; i++) t[i] = expect_of(i);
    sb.push_back(t);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else       model_step();
    push_exp();
    #1;
  endtask

  task automatic drive(input logic e, input logic m, input logic l, input logic [3:0] sv, input int n);
    en = e; mode = m; load = l; s = sv;
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Reset lands 1ns after an edge; the next negedge check sees reset values with no clock edge between.
  task automatic async_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    push_exp();
  endtask

  task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t actual=%h expected=%h", name, i, $time, act, exp);
    end
  endtask

  trio_t mon_e;
  trio_t mon_a;

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        mon_a[0] = '{out_a, idx_a, wrap_a, oor_a};
        mon_a[1] = '{{6'b0, out_b}, idx_b, wrap_b, oor_b};
        mon_a[2] = '{out_c, idx_c, wrap_c, oor_c};
        for (int i = 0; i < 3; i++) begin
          chk("out",  i, mon_a[i].out, mon_e[i].out);
          chk("idx",  i, 16'(mon_a[i].idx), 16'(mon_e[i].idx));
          chk("wrap", i, 16'(mon_a[i].wrap), 16'(mon_e[i].wrap));
          chk("oor",  i, 16'(mon_a[i].oor), 16'(mon_e[i].oor));
        end
      end
    end
  end

  initial begin
    model_reset();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 3);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd0, 8);
    drive(1'b1, 1'b0, 1'b1, 4'hB, 1);
    drive(1'b1, 1'b0, 1'b0, 4'h3, 3);
    drive(1'b1, 1'b0, 1'b1, 4'hF, 1);
    drive(1'b1, 1'b1, 1'b0, 4'h0, 140);
    drive(1'b1, 1'b0, 1'b1, 4'd12, 1);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 2);
    drive(1'b1, 1'b0, 1'b1, 4'd9, 1);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 60);
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 3);
    drive(1'b1, 1'b1, 1'b1, 4'd5, 1);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 6);
    drive(1'b1, 1'b1, 1'b1, 4'd13, 1);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 5);
    drive(1'b0, 1'b1, 1'b0, 4'd0, 3);
    drive(1'b1, 1'b1, 1'b0, 4'd0, 6);
    async_reset();
    drive(1'b1, 1'b1, 1'b0, 4'd0, 2);
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 4'd0, 6);
    for (int k = 0; k < 700; k++) begin
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 7) == 0);
      s    = 4'($urandom_range(0, 15));
      cycle();
    end
    load = 1'b0;
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d expected=0 pending entries", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
